typewriter_cycle_sequencer: RTL and testbench
=============================================

# typewriter_cycle_sequencer

Clocked sequencer for the console typewriter that replaces the free-running CRCB cam model with a controlled cam revolution. It accepts one typewriter operation at a time: print character, space, carriage return, tab or shift. It inserts an automatic shift cycle when the character's case differs from the current shift state. It then drives the print magnets and function solenoids against the CRCB contact windows. It sits between the typewriter control relay logic, which issues requests, and the mechanical typewriter model, which returns the interlock contacts.

## Interface
Parameters:
- DEG_DIV, default 4: clocks per cam degree (1..255).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  operation request.
- req_ready  out  1  sequencer can accept; high only in IDLE.
- req_op  in  3  operation code: 0 char, 1 space, 2 carriage return, 3 tab, 4 shift-upper, 5 shift-lower; 6 and 7 are reserved and treated as a no-op.
- req_char  in  6  character code, used for op 0.
- req_upper  in  1  character requires upper case, used for op 0.
- carr_rtn_intlk  in  1  carriage-return interlock contact (1 = return in progress).
- tab_intlk  in  1  tab interlock contact (1 = tab in progress).
- cam_angle  out  9  current cam angle, 0..359.
- crcb  out  6  CRCB contacts 1..6 (bit0 = contact 1).
- mag_code  out  6  latched character to the print magnets.
- mag_fire  out  1  print magnets energised.
- space_sol, cr_sol, tab_sol, shift_sol  out  1 each  function solenoids.
- shift_state  out  1  1 = upper case.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-clock completion pulse.

## Operation
- A request is accepted on a clock edge where req_valid and req_ready are both high. On acceptance, req_op, req_char and req_upper are latched. Inputs presented at any other time are ignored.
- States:
  - IDLE
  - SHIFT_CYC: one cam revolution.
  - PRINT_CYC: one cam revolution.
  - SPACE_CYC: one cam revolution.
  - FUNC_WAIT: no cam motion.
  - DONE: one clock.
- Transitions out of IDLE on acceptance:
  - op 0 with req_upper ≠ shift_state goes to SHIFT_CYC, then PRINT_CYC, then DONE.
  - op 0 with req_upper = shift_state goes to PRINT_CYC, then DONE.
  - op 1 goes to SPACE_CYC, then DONE.
  - op 2 and op 3 go to FUNC_WAIT, then DONE.
  - op 4 or op 5: if the requested state differs from shift_state, go to SHIFT_CYC, then DONE; otherwise go directly to DONE.
  - op 6 and op 7 go directly to DONE.
- Cam behaviour:
  - During any revolution state, a prescaler counts 0..DEG_DIV-1. cam_angle increments on each wrap of the prescaler.
  - On the tick at angle 359, cam_angle returns to 0 and the revolution ends.
  - Outside the revolution states, cam_angle is 0, the prescaler is 0 and crcb is 000000.
- CRCB windows: each contact is high while a revolution is running and cam_angle is within its half-open range.
  - crcb[0]: [0,51)
  - crcb[1]: [50,100)
  - crcb[2]: [99,309)
  - crcb[3]: [171,221)
  - crcb[4]: [220,300)
  - crcb[5]: [310,360)
- SHIFT_CYC:
  - shift_sol equals crcb[0] | crcb[1].
  - shift_state toggles on the final tick of the revolution, exactly once per shift cycle.
- PRINT_CYC:
  - mag_code holds the latched character from entry to the state until the next acceptance.
  - mag_fire equals crcb[0].
- SPACE_CYC: space_sol equals crcb[0].
- FUNC_WAIT has three phases:
  - Phase A: the solenoid (cr_sol for op 2, tab_sol for op 3) is high until the matching interlock reads 1.
  - Phase B: the solenoid drops and the sequencer waits for the interlock to read 0.
  - After phase B, the state goes to DONE.
  - There is no timeout; a stuck interlock holds busy high indefinitely.
- DONE:
  - done = 1 for one clock, then the state returns to IDLE.
  - req_ready is low in DONE and high again on the following clock.
- Reset values:
  - State IDLE.
  - cam_angle = 0, crcb = 0, mag_code = 0.
  - All solenoids 0, mag_fire = 0.
  - shift_state = 0 (lower case).
  - busy = 0, done = 0, req_ready = 1.
- Reset mid-operation returns immediately to the reset values. This includes the case where reset arrives mid-shift-cycle: shift_state becomes 0 and no done pulse is produced.

## Timing
- All outputs are registered, with the exception of crcb, mag_fire and the solenoids. These decode combinationally from the registered cam_angle, the registered state and the run flag, so they change in the same cycle as cam_angle.
- One revolution takes 360·DEG_DIV clocks.
- Latencies, counted in clocks from the acceptance edge to the done pulse:
  - Print with matching case, space, or shift with a state change: 360·DEG_DIV + 1.
  - Print with a case change: 720·DEG_DIV + 1.
  - No-op, or shift with no state change: 1.
- Back-to-back requests: the next request can be accepted two clocks after the final cam tick (DONE, then IDLE).
- mag_fire is high for 51·DEG_DIV clocks per print.
- Interlock inputs are sampled on clk and must not be used asynchronously.

## Test plan
- Reset with DEG_DIV = 1: all outputs equal the reset values and req_ready = 1. Deassert rst_n and hold req_valid low for 500 clocks: no output changes.
- DEG_DIV = 1, op 0, char 6'o21, req_upper = 0: mag_code = 21 (octal); mag_fire high for 51 clocks starting the clock after acceptance; crcb[2] high for 210 clocks; done pulses 361 clocks after acceptance; shift_state stays 0.
- DEG_DIV = 2, op 0 with req_upper = 1 from lower case: shift_sol high for 200 clocks; shift_state becomes 1 at clock 720; mag_fire high for 102 clocks in the second revolution; done at clock 1441.
- op 2: cr_sol is high until carr_rtn_intlk rises (drive it 10 clocks later); hold the interlock high 30 clocks, then drop it; done arrives 1–2 clocks after the drop; cam_angle stays 0 throughout.
- Pulse req_valid with op 1 while busy: the request is ignored and there is exactly one done pulse. Issue op 5 while already lower case: done arrives the next clock with no solenoid activity.
- Assert rst_n low at angle 120 of a shift cycle: all outputs return to the reset values asynchronously and shift_state = 0. The following op 0 request is accepted normally.

Source files
------------

// File: rtl/typewriter_cycle_sequencer.sv
// Console typewriter cycle sequencer: runs one controlled CRCB cam revolution per
// print/space/shift operation and handshakes carriage-return/tab with their interlocks.
module typewriter_cycle_sequencer #(
   parameter int unsigned DEG_DIV = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [2:0] req_op,
   input  logic [5:0] req_char,
   input  logic       req_upper,
   input  logic       carr_rtn_intlk,
   input  logic       tab_intlk,
   output logic [8:0] cam_angle,
   output logic [5:0] crcb,
   output logic [5:0] mag_code,
   output logic       mag_fire,
   output logic       space_sol,
   output logic       cr_sol,
   output logic       tab_sol,
   output logic       shift_sol,
   output logic       shift_state,
   output logic       busy,
   output logic       done
);

   localparam logic [7:0] PrescMax = 8'(DEG_DIV - 1);
   localparam logic [2:0] OpChar   = 3'd0;
   localparam logic [2:0] OpSpace  = 3'd1;
   localparam logic [2:0] OpCr     = 3'd2;
   localparam logic [2:0] OpTab    = 3'd3;
   localparam logic [2:0] OpUpper  = 3'd4;
   localparam logic [2:0] OpLower  = 3'd5;

   typedef enum logic [2:0] {
      StIdle,
      StShift,
      StPrint,
      StSpace,
      StFuncWait,
      StDone
   } state_e;

   state_e     state_q, state_d;
   logic [7:0] presc_q, presc_d;
   logic [8:0] angle_q, angle_d;
   logic [2:0] op_q, op_d;
   logic [5:0] char_q, char_d;
   logic [5:0] mag_code_q, mag_code_d;
   logic       shift_state_q, shift_state_d;
   // 0: solenoid pulling, waiting for interlock to make; 1: waiting for it to break
   logic       phase_q, phase_d;

   logic run, tick, last_tick, intlk;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         presc_q       <= 8'd0;
         angle_q       <= 9'd0;
         op_q          <= 3'd0;
         char_q        <= 6'd0;
         mag_code_q    <= 6'd0;
         shift_state_q <= 1'b0;
         phase_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         presc_q       <= presc_d;
         angle_q       <= angle_d;
         op_q          <= op_d;
         char_q        <= char_d;
         mag_code_q    <= mag_code_d;
         shift_state_q <= shift_state_d;
         phase_q       <= phase_d;
      end
   end

   assign run       = (state_q == StShift) || (state_q == StPrint) || (state_q == StSpace);
   assign tick      = run && (presc_q == PrescMax);
   assign last_tick = tick && (angle_q == 9'd359);
   assign intlk     = (op_q == OpCr) ? carr_rtn_intlk : tab_intlk;

   always_comb begin
      state_d       = state_q;
      presc_d       = presc_q;
      angle_d       = angle_q;
      op_d          = op_q;
      char_d        = char_q;
      mag_code_d    = mag_code_q;
      shift_state_d = shift_state_q;
      phase_d       = phase_q;

      if (run) begin
         if (tick) begin
            presc_d = 8'd0;
            angle_d = last_tick ? 9'd0 : angle_q + 9'd1;
         end else begin
            presc_d = presc_q + 8'd1;
         end
      end

      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               op_d    = req_op;
               char_d  = req_char;
               phase_d = 1'b0;
               case (req_op)
                  OpChar: begin
                     if (req_upper != shift_state_q) begin
                        state_d = StShift;
                     end else begin
                        state_d    = StPrint;
                        mag_code_d = req_char;
                     end
                  end
                  OpSpace: state_d = StSpace;
                  OpCr, OpTab: state_d = StFuncWait;
                  OpUpper: state_d = shift_state_q ? StDone : StShift;
                  OpLower: state_d = shift_state_q ? StShift : StDone;
                  default: state_d = StDone;
               endcase
            end
         end
         StShift: begin
            if (last_tick) begin
               shift_state_d = ~shift_state_q;
               if (op_q == OpChar) begin
                  state_d    = StPrint;
                  mag_code_d = char_q;
               end else begin
                  state_d = StDone;
               end
            end
         end
         StPrint, StSpace: begin
            if (last_tick) state_d = StDone;
         end
         StFuncWait: begin
            if (!phase_q) begin
               if (intlk) phase_d = 1'b1;
            end else if (!intlk) begin
               state_d = StDone;
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Contact windows are half-open [lo, hi) in cam degrees.
   always_comb begin
      crcb = 6'd0;
      if (run) begin
         crcb[0] = (angle_q < 9'd51);
         crcb[1] = (angle_q >= 9'd50)  && (angle_q < 9'd100);
         crcb[2] = (angle_q >= 9'd99)  && (angle_q < 9'd309);
         crcb[3] = (angle_q >= 9'd171) && (angle_q < 9'd221);
         crcb[4] = (angle_q >= 9'd220) && (angle_q < 9'd300);
         crcb[5] = (angle_q >= 9'd310);
      end
   end

   assign mag_fire    = (state_q == StPrint) && crcb[0];
   assign space_sol   = (state_q == StSpace) && crcb[0];
   assign shift_sol   = (state_q == StShift) && (crcb[0] | crcb[1]);
   assign cr_sol      = (state_q == StFuncWait) && !phase_q && (op_q == OpCr);
   assign tab_sol     = (state_q == StFuncWait) && !phase_q && (op_q == OpTab);

   assign cam_angle   = angle_q;
   assign mag_code    = mag_code_q;
   assign shift_state = shift_state_q;
   assign req_ready   = (state_q == StIdle);
   assign busy        = (state_q != StIdle);
   assign done        = (state_q == StDone);

endmodule

// File: tb/tb_typewriter_cycle_sequencer.sv
// Directed bench for typewriter_cycle_sequencer; instance a runs DEG_DIV=1, instance b DEG_DIV=2.
module tb_typewriter_cycle_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] req_op;
   logic [5:0] req_char;
   logic       req_upper;
   logic       cr_intlk, tab_intlk;
   logic       valid_a, valid_b;

   logic       ready_a, busy_a, done_a, mag_fire_a, space_a, cr_a, tab_a, shsol_a, shst_a;
   logic [8:0] angle_a;
   logic [5:0] crcb_a, code_a;
   logic       ready_b, busy_b, done_b, mag_fire_b, space_b, cr_b, tab_b, shsol_b, shst_b;
   logic [8:0] angle_b;
   logic [5:0] crcb_b, code_b;

   int n_total = 0;
   int n_bad   = 0;

   localparam logic [29:0] RstVec = 30'h2000_0000;

   always #5 clk = ~clk;

   typewriter_cycle_sequencer #(.DEG_DIV(1)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .req_valid(valid_a), .req_ready(ready_a), .req_op(req_op),
      .req_char(req_char), .req_upper(req_upper), .carr_rtn_intlk(cr_intlk),
      .tab_intlk(tab_intlk), .cam_angle(angle_a), .crcb(crcb_a), .mag_code(code_a),
      .mag_fire(mag_fire_a), .space_sol(space_a), .cr_sol(cr_a), .tab_sol(tab_a),
      .shift_sol(shsol_a), .shift_state(shst_a), .busy(busy_a), .done(done_a)
   );

   typewriter_cycle_sequencer #(.DEG_DIV(2)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .req_valid(valid_b), .req_ready(ready_b), .req_op(req_op),
      .req_char(req_char), .req_upper(req_upper), .carr_rtn_intlk(1'b0),
      .tab_intlk(1'b0), .cam_angle(angle_b), .crcb(crcb_b), .mag_code(code_b),
      .mag_fire(mag_fire_b), .space_sol(space_b), .cr_sol(cr_b), .tab_sol(tab_b),
      .shift_sol(shsol_b), .shift_state(shst_b), .busy(busy_b), .done(done_b)
   );

   function automatic logic [29:0] pack_a();
      return {ready_a, busy_a, done_a, angle_a, crcb_a, code_a,
              mag_fire_a, space_a, cr_a, tab_a, shsol_a, shst_a};
   endfunction

   function automatic logic [29:0] pack_b();
      return {ready_b, busy_b, done_b, angle_b, crcb_b, code_b,
              mag_fire_b, space_b, cr_b, tab_b, shsol_b, shst_b};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Returns just after the acceptance edge; the next negedge is cycle 1.
   task automatic issue(input bit sel, input logic [2:0] op, input logic [5:0] ch,
                        input logic up);
      int w;
      w = 0;
      @(negedge clk);
      while (((sel ? ready_b : ready_a) !== 1'b1) && (w < 100)) begin
         @(negedge clk);
         w++;
      end
      check("accept_ready", 32'(sel ? ready_b : ready_a), 32'd1);
      req_op    = op;
      req_char  = ch;
      req_upper = up;
      if (sel) valid_b = 1'b1;
      else     valid_a = 1'b1;
      @(posedge clk);
      #1;
      valid_a = 1'b0;
      valid_b = 1'b0;
   endtask

   initial begin
      int mf_cnt, mf_first, c2_cnt, done_n, done_cnt, sh_max, sol_cnt, ang_max, w;

      rst_n = 1'b0; req_op = 3'd0; req_char = 6'd0; req_upper = 1'b0;
      cr_intlk = 1'b0; tab_intlk = 1'b0; valid_a = 1'b0; valid_b = 1'b0;

      // Reset values, then 500 idle clocks with no change
      #3;
      check("reset_a", 32'(pack_a()), 32'(RstVec));
      check("reset_b", 32'(pack_b()), 32'(RstVec));
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         check("idle_hold_a", 32'(pack_a()), 32'(RstVec));
      end

      // Print 021 lower case, DEG_DIV=1
      issue(1'b0, 3'd0, 6'o21, 1'b0);
      mf_cnt = 0; mf_first = 0; c2_cnt = 0; done_n = 0; sh_max = 0;
      for (int n = 1; n <= 2000 && done_n == 0; n++) begin
         @(negedge clk);
         if (n == 1) check("print_mag_code", 32'(code_a), 32'o21);
         if (mag_fire_a) begin
            mf_cnt++;
            if (mf_first == 0) mf_first = n;
         end
         if (crcb_a[2]) c2_cnt++;
         if (shst_a) sh_max = 1;
         if (done_a) done_n = n;
      end
      check("print_mf_count", 32'(mf_cnt), 32'd51);
      check("print_mf_first", 32'(mf_first), 32'd1);
      check("print_crcb2", 32'(c2_cnt), 32'd210);
      check("print_done_lat", 32'(done_n), 32'd361);
      check("print_shift_st", 32'(sh_max), 32'd0);
      @(negedge clk);
      check("print_ready_after", 32'({ready_a, done_a}), 32'b10);

      // Print upper case from lower, DEG_DIV=2
      issue(1'b1, 3'd0, 6'o44, 1'b1);
      sol_cnt = 0; mf_cnt = 0; done_n = 0;
      for (int n = 1; n <= 4000 && done_n == 0; n++) begin
         @(negedge clk);
         if (shsol_b) sol_cnt++;
         if (mag_fire_b && n > 720) mf_cnt++;
         if (mag_fire_b && n <= 720) mf_cnt += 1000;
         if (n == 720) check("case_shst_before", 32'(shst_b), 32'd0);
         if (n == 721) check("case_shst_after", 32'(shst_b), 32'd1);
         if (n == 721) check("case_mag_code", 32'(code_b), 32'o44);
         if (done_b) done_n = n;
      end
      check("case_shift_sol", 32'(sol_cnt), 32'd200);
      check("case_mf_count", 32'(mf_cnt), 32'd102);
      check("case_done_lat", 32'(done_n), 32'd1441);

      // Carriage return handshake, DEG_DIV=1
      issue(1'b0, 3'd2, 6'd0, 1'b0);
      sol_cnt = 0; ang_max = 0;
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         if (cr_a) sol_cnt++;
         if (32'(angle_a) > ang_max) ang_max = 32'(angle_a);
      end
      check("cr_sol_phase_a", 32'(sol_cnt), 32'd10);
      cr_intlk = 1'b1;
      sol_cnt = 0; done_cnt = 0; w = 0;
      for (int n = 0; n < 30; n++) begin
         @(negedge clk);
         if (cr_a) sol_cnt++;
         if (done_a) done_cnt++;
         if (busy_a) w++;
         if (32'(angle_a) > ang_max) ang_max = 32'(angle_a);
      end
      check("cr_sol_phase_b", 32'(sol_cnt), 32'd0);
      check("cr_hold_busy", 32'(w), 32'd30);
      check("cr_hold_nodone", 32'(done_cnt), 32'd0);
      cr_intlk = 1'b0;
      done_n = 0;
      for (int n = 1; n <= 4 && done_n == 0; n++) begin
         @(negedge clk);
         if (done_a) done_n = n;
      end
      check("cr_done_lat_ok", 32'(done_n >= 1 && done_n <= 2), 32'd1);
      check("cr_angle", 32'(ang_max), 32'd0);

      // Space with an ignored request while busy
      issue(1'b0, 3'd1, 6'd0, 1'b0);
      done_cnt = 0; done_n = 0; sol_cnt = 0;
      for (int n = 1; n <= 420; n++) begin
         @(negedge clk);
         if (done_a) begin
            done_cnt++;
            done_n = n;
         end
         if (space_a) sol_cnt++;
         if (n == 5) begin
            req_op = 3'd1;
            valid_a = 1'b1;
            @(posedge clk);
            #1;
            valid_a = 1'b0;
         end
      end
      check("space_done_count", 32'(done_cnt), 32'd1);
      check("space_done_lat", 32'(done_n), 32'd361);
      check("space_sol_count", 32'(sol_cnt), 32'd51);

      // Shift-lower while already lower: immediate done, no solenoids
      issue(1'b0, 3'd5, 6'd0, 1'b0);
      @(negedge clk);
      check("noop_shift_done", 32'(done_a), 32'd1);
      check("noop_shift_sols", 32'({shsol_a, space_a, cr_a, tab_a, mag_fire_a, shst_a}), 32'd0);
      @(negedge clk);
      check("noop_shift_idle", 32'({ready_a, busy_a, done_a}), 32'b100);

      // Reset in the middle of a shift cycle (b is upper case here)
      issue(1'b1, 3'd5, 6'd0, 1'b0);
      w = 0;
      while (angle_b != 9'd120 && w < 2000) begin
         @(negedge clk);
         w++;
      end
      check("midrst_reach_120", 32'(angle_b), 32'd120);
      check("midrst_shsol", 32'(shsol_b), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_vec", 32'(pack_b()), 32'(RstVec));
      check("midrst_shst", 32'(shst_b), 32'd0);
      @(negedge clk);
      check("midrst_nodone", 32'(done_b), 32'd0);
      rst_n = 1'b1;
      issue(1'b1, 3'd0, 6'o05, 1'b0);
      done_n = 0;
      for (int n = 1; n <= 3000 && done_n == 0; n++) begin
         @(negedge clk);
         if (n == 1) check("post_rst_code", 32'(code_b), 32'o05);
         if (done_b) done_n = n;
      end
      check("post_rst_done_lat", 32'(done_n), 32'd721);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
